// File: rtl/desc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// desc_pkg : shared types and constants for the descriptor patch scanner
// Revision : 1.0
// ---------------------------------------------------------------------------
package desc_pkg;

    localparam int PATCH_N = 256;
    localparam int OFS_W   = 5;
    localparam int N_ORI   = 24;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SCAN  = ST_SCAN,
        S_DRAIN = ST_DRAIN
    } state_t;

endpackage
`default_nettype wire

// File: rtl/desc_coord_clamp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// desc_coord_clamp : keypoint coordinate + signed offset, saturated to [0, LIMIT-1]
// Revision : 1.0
// ---------------------------------------------------------------------------
module desc_coord_clamp
    import desc_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int LIMIT   = 640
) (
    input  logic [COORD_W-1:0] base,
    input  logic [OFS_W-1:0]   ofs,
    output logic [COORD_W-1:0] res,
    output logic               oob
);

    localparam logic signed [COORD_W:0] c_max = (COORD_W+1)'(LIMIT - 1);

    logic signed [COORD_W:0] w_sum;

    assign w_sum = $signed({1'b0, base}) + $signed({{(COORD_W+1-OFS_W){ofs[OFS_W-1]}}, ofs});

    always_comb begin
        res = w_sum[COORD_W-1:0];
        oob = 1'b0;
        if (w_sum[COORD_W]) begin
            res = '0;
            oob = 1'b1;
        end else if (w_sum > c_max) begin
            res = c_max[COORD_W-1:0];
            oob = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/desc_patch_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// desc_patch_scan_ctrl : walks the 16x16 rotated sampling patch of one keypoint
// Revision : 1.0
// ---------------------------------------------------------------------------
module desc_patch_scan_ctrl
    import desc_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int N_ORI   = desc_pkg::N_ORI
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] kp_x,
    input  logic [COORD_W-1:0] kp_y,
    input  logic [4:0]         ori,
    output logic [4:0]         rom_sel,
    output logic [7:0]         rom_a,
    input  logic [OFS_W-1:0]   rom_dx,
    input  logic [OFS_W-1:0]   rom_dy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [7:0]         out_idx,
    output logic               out_last,
    output logic               out_oob,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [7:0] c_last_idx = 8'(PATCH_N - 1);

    state_t             r_state, w_next;
    logic [7:0]         r_cnt;
    logic [COORD_W-1:0] r_kp_x, r_kp_y;
    logic [4:0]         r_sel;
    logic               r_valid, r_last, r_oob, r_done, r_cfg_err;
    logic [COORD_W-1:0] r_x, r_y;
    logic [7:0]         r_idx;
    logic               w_adv, w_accept, w_load, w_hs, w_busy;
    logic [COORD_W-1:0] w_x, w_y;
    logic               w_x_oob, w_y_oob;

    assign w_adv    = !r_valid || out_ready;
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_load   = (r_state == S_SCAN) && w_adv && !abort;
    assign w_hs     = (r_state == S_DRAIN) && r_valid && out_ready && !abort;

    desc_coord_clamp #(.COORD_W(COORD_W), .LIMIT(IMG_W)) u_clamp_x (
        .base(r_kp_x), .ofs(rom_dx), .res(w_x), .oob(w_x_oob)
    );

    desc_coord_clamp #(.COORD_W(COORD_W), .LIMIT(IMG_H)) u_clamp_y (
        .base(r_kp_y), .ofs(rom_dy), .res(w_y), .oob(w_y_oob)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SCAN;
            S_SCAN: begin
                if (abort)                              w_next = S_IDLE;
                else if (w_adv && r_cnt == c_last_idx)  w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort || (r_valid && out_ready))    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // Abort drops any in-flight sample and rewinds the walk without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_kp_x    <= '0;
            r_kp_y    <= '0;
            r_sel     <= '0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_oob     <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (abort) begin
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else begin
                if (w_accept) begin
                    r_kp_x <= kp_x;
                    r_kp_y <= kp_y;
                    r_cnt  <= '0;
                    if (int'(ori) >= N_ORI) begin
                        r_sel     <= '0;
                        r_cfg_err <= 1'b1;
                    end else begin
                        r_sel <= ori;
                    end
                end
                if (w_load) begin
                    r_x     <= w_x;
                    r_y     <= w_y;
                    r_idx   <= r_cnt;
                    r_last  <= (r_cnt == c_last_idx);
                    r_oob   <= w_x_oob | w_y_oob;
                    r_valid <= 1'b1;
                    r_cnt   <= r_cnt + 8'd1;
                end
                if (w_hs) begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign rom_sel   = r_sel;
    assign rom_a     = r_cnt;
    assign out_valid = r_valid;
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign out_oob   = r_oob;
    assign busy      = w_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_desc_patch_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_desc_patch_scan_ctrl : randomized scenario bench with a behavioural patch model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_desc_patch_scan_ctrl;

    localparam int COORD_W = 10;
    localparam int IMG_W   = 640;
    localparam int IMG_H   = 480;

    logic               clk = 1'b0;
    logic               rst, start, abort, out_ready;
    logic [COORD_W-1:0] kp_x, kp_y;
    logic [4:0]         ori;
    logic [4:0]         rom_sel;
    logic [7:0]         rom_a;
    logic [4:0]         rom_dx, rom_dy;
    logic               out_valid, out_last, out_oob, busy, done, cfg_err;
    logic [COORD_W-1:0] out_x, out_y;
    logic [7:0]         out_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Bench-side ROM bank: 24 dx tables plus one fixed dy table.
    int dxt [24][256];
    int dyt [256];

    int cap_x   [256];
    bit cap_oob [256];
    int n_hs, done_cyc, start_cyc;
    bit any_oob, got_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        rom_dx = 5'(dxt[(rom_sel < 5'd24) ? rom_sel : 5'd0][rom_a]);
        rom_dy = 5'(dyt[rom_a]);
    end

    desc_patch_scan_ctrl #(.COORD_W(COORD_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .N_ORI(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .kp_x(kp_x), .kp_y(kp_y), .ori(ori),
        .rom_sel(rom_sel), .rom_a(rom_a), .rom_dx(rom_dx), .rom_dy(rom_dy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_idx(out_idx), .out_last(out_last),
        .out_oob(out_oob), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    function automatic int sat(input int v, input int lim);
        return (v < 0) ? 0 : ((v > lim - 1) ? lim - 1 : v);
    endfunction

    task automatic check_all_zero(input string name);
        checks++;
        if (out_valid !== 0 || out_x !== 0 || out_y !== 0 || out_idx !== 0 || out_last !== 0 ||
            out_oob !== 0 || busy !== 0 || done !== 0 || cfg_err !== 0 || rom_a !== 0 || rom_sel !== 0) begin
            failures++;
            $display("FAIL %s: got valid=%0b x=%0d y=%0d idx=%0d last=%0b oob=%0b busy=%0b done=%0b cfg_err=%0b rom_a=%0d rom_sel=%0d, required all 0",
                     name, out_valid, out_x, out_y, out_idx, out_last, out_oob, busy, done, cfg_err, rom_a, rom_sel);
        end
    endtask

    task automatic run_scan(input int kx, input int ky, input int o, input int rdy_pct,
                            input int abort_at, input int rst_at, input int busy_at);
        int tab, e, last_hs, vx, vy, ex, ey;
        bit fin, stall, eoob;
        logic [COORD_W-1:0] sx, sy;
        logic [7:0] si;
        logic sl, so;
        tab = (o >= 24) ? 0 : o;
        e = 0; last_hs = -10; fin = 0; stall = 0;
        n_hs = 0; any_oob = 0; got_done = 0;
        sx = '0; sy = '0; si = '0; sl = 0; so = 0;
        @(negedge clk);
        start = 1; kp_x = 10'(kx); kp_y = 10'(ky); ori = 5'(o); out_ready = 1; start_cyc = cyc;
        @(negedge clk);
        start = 0; kp_x = 10'($urandom_range(639)); kp_y = 10'($urandom_range(479)); ori = 5'($urandom_range(31));
        checks++;
        if (cfg_err !== (o >= 24) || rom_sel !== 5'(tab) || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_latch: got cfg_err=%0b rom_sel=%0d busy=%0b, required cfg_err=%0b rom_sel=%0d busy=1",
                     cfg_err, rom_sel, busy, (o >= 24), tab);
        end
        for (int it = 0; it < 4000 && !fin; it++) begin
            @(negedge clk);
            start = 0;
            checks++;
            if (cfg_err !== 1'b0) begin
                failures++;
                $display("FAIL cfg_err_pulse: got %0b, required 0", cfg_err);
            end
            if (done) begin
                got_done = 1; done_cyc = cyc; fin = 1;
                checks++;
                if (e != 256 || cyc != last_hs + 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL done_timing: got samples=%0d cyc=%0d busy=%0b valid=%0b, required samples=256 cyc=%0d busy=0 valid=0",
                             e, cyc, busy, out_valid, last_hs + 1);
                end
            end else if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_x !== sx || out_y !== sy || out_idx !== si || out_last !== sl || out_oob !== so) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0b x=%0d y=%0d idx=%0d, required valid=1 x=%0d y=%0d idx=%0d",
                             out_valid, out_x, out_y, out_idx, sx, sy, si);
                end
            end
            if (!fin && out_valid) begin
                checks++;
                if (e > 255) begin
                    failures++;
                    $display("FAIL extra_sample: got idx=%0d, required no sample after 256", out_idx);
                end else begin
                    vx = kx + dxt[tab][e];
                    vy = ky + dyt[e];
                    ex = sat(vx, IMG_W);
                    ey = sat(vy, IMG_H);
                    eoob = (vx != ex) || (vy != ey);
                    if (out_idx !== 8'(e) || out_x !== 10'(ex) || out_y !== 10'(ey) ||
                        out_last !== (e == 255) || out_oob !== eoob) begin
                        failures++;
                        $display("FAIL sample: got idx=%0d x=%0d y=%0d last=%0b oob=%0b, required idx=%0d x=%0d y=%0d last=%0b oob=%0b",
                                 out_idx, out_x, out_y, out_last, out_oob, e, ex, ey, (e == 255), eoob);
                    end
                end
                if (e == abort_at) begin
                    abort = 1;
                    @(negedge clk);
                    abort = 0;
                    checks++;
                    if (out_valid !== 0 || busy !== 0 || rom_a !== 0 || done !== 0) begin
                        failures++;
                        $display("FAIL abort: got valid=%0b busy=%0b rom_a=%0d done=%0b, required all 0",
                                 out_valid, busy, rom_a, done);
                    end
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        checks++;
                        if (done !== 0 || out_valid !== 0) begin
                            failures++;
                            $display("FAIL abort_quiet: got done=%0b valid=%0b, required 0 0", done, out_valid);
                        end
                    end
                    fin = 1;
                end else if (e == rst_at) begin
                    rst = 1;
                    @(negedge clk);
                    rst = 0;
                    check_all_zero("mid_reset");
                    fin = 1;
                end else if (e == busy_at) begin
                    start = 1;
                    kp_x = 10'($urandom_range(639));
                    kp_y = 10'($urandom_range(479));
                    ori = 5'((tab + 7) % 24);
                end
            end
            if (!fin) begin
                out_ready = ($urandom_range(99) < rdy_pct);
                stall = out_valid && !out_ready;
                sx = out_x; sy = out_y; si = out_idx; sl = out_last; so = out_oob;
                if (out_valid && out_ready && e < 256) begin
                    cap_x[e] = out_x; cap_oob[e] = out_oob;
                    any_oob |= out_oob;
                    e++; n_hs++; last_hs = cyc;
                end
            end
        end
        if (!fin) begin
            checks++; failures++;
            $display("FAIL scan_timeout: got samples=%0d, required scan to finish", e);
        end
        if (got_done) begin
            @(negedge clk);
            checks++;
            if (done !== 0) begin
                failures++;
                $display("FAIL done_width: got %0b one cycle later, required 0", done);
            end
        end
    endtask

    task automatic expect_full(input string name);
        checks++;
        if (n_hs != 256 || !got_done) begin
            failures++;
            $display("FAIL %s: got handshakes=%0d done=%0b, required 256 1", name, n_hs, got_done);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; abort = 0; out_ready = 0; kp_x = '0; kp_y = '0; ori = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_all_zero("reset_state");
    endtask

    task automatic test_nominal();
        run_scan(100, 100, 2, 100, -1, -1, -1);
        expect_full("nominal_count");
        checks++;
        if (cap_x[0] != 111 || cap_x[95] != 99 || cap_x[255] != 90) begin
            failures++;
            $display("FAIL nominal_points: got x0=%0d x95=%0d x255=%0d, required 111 99 90", cap_x[0], cap_x[95], cap_x[255]);
        end
        checks++;
        if (done_cyc - start_cyc + 1 != 259) begin
            failures++;
            $display("FAIL start_to_done: got %0d cycles, required 259", done_cyc - start_cyc + 1);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 2; r++) begin
            run_scan(20 + $urandom_range(580), 20 + $urandom_range(440), $urandom_range(23), 50, -1, -1, -1);
            expect_full("backpressure_count");
        end
    endtask

    task automatic test_clamp();
        run_scan(5, 200, 2, 100, -1, -1, -1);
        checks++;
        if (cap_x[255] != 0 || cap_oob[255] != 1) begin
            failures++;
            $display("FAIL clamp_low: got x=%0d oob=%0b, required 0 1", cap_x[255], cap_oob[255]);
        end
        run_scan(637, 200, 2, 100, -1, -1, -1);
        checks++;
        if (cap_x[0] != 639 || cap_oob[0] != 1) begin
            failures++;
            $display("FAIL clamp_high: got x=%0d oob=%0b, required 639 1", cap_x[0], cap_oob[0]);
        end
        run_scan(320, 240, $urandom_range(23), 70, -1, -1, -1);
        checks++;
        if (any_oob != 0 || n_hs != 256) begin
            failures++;
            $display("FAIL clamp_centre: got any_oob=%0b handshakes=%0d, required 0 256", any_oob, n_hs);
        end
    endtask

    task automatic test_busy_start();
        run_scan(200, 150, 5, 100, -1, -1, 50);
        expect_full("busy_start_count");
        checks++;
        if (rom_sel !== 5'd5) begin
            failures++;
            $display("FAIL busy_start_sel: got rom_sel=%0d, required 5", rom_sel);
        end
    endtask

    task automatic test_abort();
        run_scan(300, 200, 7, 100, 100, -1, -1);
        run_scan(300, 200, 7, 100, -1, -1, -1);
        expect_full("after_abort_count");
        @(negedge clk);
        start = 1; abort = 1; ori = 5'd3;
        @(negedge clk);
        start = 0; abort = 0;
        checks++;
        if (busy !== 0 || cfg_err !== 0) begin
            failures++;
            $display("FAIL abort_beats_start: got busy=%0b cfg_err=%0b, required 0 0", busy, cfg_err);
        end
    endtask

    task automatic test_mid_reset();
        run_scan(400, 300, 11, 100, -1, 30, -1);
        run_scan(400, 300, 11, 60, -1, -1, -1);
        expect_full("after_reset_count");
    endtask

    task automatic test_bad_ori();
        run_scan(150, 150, 30, 100, -1, -1, -1);
        expect_full("bad_ori_count");
    endtask

    initial begin
        for (int t = 0; t < 24; t++)
            for (int a = 0; a < 256; a++)
                dxt[t][a] = int'($urandom_range(31)) - 16;
        for (int a = 0; a < 256; a++)
            dyt[a] = int'($urandom_range(31)) - 16;
        dxt[2][0]   = 11;
        dxt[2][95]  = -1;
        dxt[2][255] = -10;

        test_reset();
        test_nominal();
        test_backpressure();
        test_clamp();
        test_busy_start();
        test_abort();
        test_mid_reset();
        test_bad_ori();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/desc_patch_scan_ctrl.md
Name: desc_patch_scan_ctrl

Overview:
Sequences the 16x16 descriptor sampling patch around one keypoint through the rotation-offset ROM bank (the dir24_* family). The bank is combinational: 8-bit address {row[3:0], col[3:0]}, and each table returns a 5-bit two's-complement offset.
The block latches the keypoint and orientation bin, selects the ROM table, walks all 256 addresses, and adds the signed dx/dy offsets to the keypoint. It emits clamped absolute sample coordinates to the pixel-fetch stage over a valid/ready stream.

Parameters:
COORD_W, 10, width of image coordinates
IMG_W, 640, image width in pixels; x is clamped to [0, IMG_W-1]
IMG_H, 480, image height in pixels; y is clamped to [0, IMG_H-1]
N_ORI, 24, number of orientation bins / ROM tables

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a patch scan; accepted only in IDLE
abort  in  1  synchronous scan cancel
kp_x  in  COORD_W  keypoint x, latched on start
kp_y  in  COORD_W  keypoint y, latched on start
ori  in  5  orientation bin, latched on start
rom_sel  out  5  ROM table select (latched ori)
rom_a  out  8  ROM address = scan counter
rom_dx  in  5  signed x offset from the selected table, same cycle as rom_a
rom_dy  in  5  signed y offset from the selected table, same cycle as rom_a
out_valid  out  1  sample valid
out_ready  in  1  downstream ready
out_x  out  COORD_W  clamped sample x
out_y  out  COORD_W  clamped sample y
out_idx  out  8  patch index of the sample
out_last  out  1  high with idx 255
out_oob  out  1  x or y was clamped
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at scan completion
cfg_err  out  1  one-cycle pulse when an out-of-range ori is accepted

Behaviour:
- Reset value of every output is 0: out_*, busy, done, cfg_err, rom_a, rom_sel. State -> IDLE, counter cnt = 0.
- States: IDLE, SCAN, DRAIN.
- IDLE, on start:
  - Latch kp_x, kp_y, ori; cnt = 0; go to SCAN.
  - If ori >= N_ORI: rom_sel = 0 and cfg_err pulses the next cycle.
- start is ignored in SCAN and DRAIN.
- adv = !out_valid || out_ready.
- SCAN, when adv:
  - Output register loads x = clamp(kp_x + sext(rom_dx)) and y = clamp(kp_y + sext(rom_dy)).
  - Also loads idx = cnt, last = (cnt == 255), oob flag; out_valid = 1; cnt increments.
  - On loading cnt == 255, go to DRAIN.
- SCAN, when not adv: cnt holds, and all out_* hold stable.
- DRAIN:
  - When out_valid && out_ready: out_valid -> 0, then done pulses the next cycle and the state returns to IDLE.
- Timing with out_ready held high:
  - First out_valid appears 2 cycles after the start cycle (1 cycle to latch, 1 cycle ROM + register).
  - Throughput is 1 sample/cycle, 256 samples total.
  - done asserts 1 cycle after the idx 255 handshake.
- Arithmetic:
  - Sum is computed at COORD_W+1 bits signed; offset range is -16..+15.
  - Sum < 0 -> 0, oob = 1. Sum > limit-1 -> limit-1, oob = 1. limit is IMG_W for x and IMG_H for y.
  - out_oob = x_oob | y_oob.
- abort (any state): next cycle out_valid = 0, state IDLE, cnt = 0, no done pulse. Any in-flight sample is dropped.
- abort coincident with start in IDLE: abort wins.
- rst mid-scan: identical to reset; no done pulse.
- rom_a = cnt at all times; rom_sel holds its value until the next accepted start.

Decomposition:
- Shared package desc_pkg holds:
  - State enum.
  - PATCH_N = 256.
  - OFS_W = 5.
  - N_ORI default.
- One sub-module, desc_coord_clamp (signed add + saturate + oob flag, parameterised by limit), instantiated twice (x, y).

Test Plan:
- Nominal scan:
  - Stimulus: ori=2, kp=(100,100), out_ready=1; bench ROM model for table 2 dx (dir24_2 contents), with a fixed dy table.
  - Required: idx0 x=111 (0xb); idx95 x=99 (0x1f); idx255 x=90 (0x16) with out_last=1.
  - Required: exactly 256 handshakes, done 1 cycle after the last one, start-to-done = 259 cycles.
- Backpressure:
  - Stimulus: out_ready pseudo-random ~50%.
  - Required: out_* stable while stalled, idx strictly 0..255 with no gaps or duplicates, done only after the idx 255 handshake.
- Clamp:
  - kp_x=5, table 2: idx255 -> x=0, out_oob=1.
  - kp_x=637: idx0 -> x=639, out_oob=1.
  - kp at (320,240): out_oob=0 throughout.
- start while busy: start pulse at idx 50 -> ignored; kp and ori unchanged, scan completes normally.
- Abort and reset:
  - abort at idx 100 -> out_valid=0 next cycle, IDLE, no done.
  - rst at idx 30 -> all outputs 0.
  - A new start after either produces a clean scan from idx0.
- Bad orientation: ori=30 -> cfg_err pulse, rom_sel=0, scan proceeds using table 0.
